mac_pipe: RTL and testbench

- Parametrised, pipelined unsigned multiply-accumulate unit; next generation of the 16x16 split-multiplier datapath.
- Each operand is split into high and low halves. Four half-width partial products are formed, then combined and accumulated over a packet of beats.
- Valid/ready streaming on input and output, with full backpressure. Sits between operand sources and the result sink in the MAC subsystem.

---
 rtl/mac_pkg.sv | 15 +
 rtl/mac_half_mult.sv | 10 +
 rtl/mac_pipe.sv | 164 ++++++++++++++++
 tb/tb_mac_pipe.sv | 184 ++++++++++++++++++
 4 files changed

// File: rtl/mac_pkg.sv
// Shared constants and the S2 partial-product bundle for the mac_pipe datapath.
package mac_pkg;
  localparam int MAC_WIDTH_DEF     = 16;
  localparam int MAC_ACC_WIDTH_DEF = 40;
  localparam int MAC_CNT_WIDTH_DEF = 8;

  // Product slot width inside the bundle; covers WIDTH up to 32 (products are WIDTH bits).
  localparam int MAC_PP_W = 32;

  typedef struct packed {
    logic [3:0][MAC_PP_W-1:0] pp;   // aL*bL, aH*bL, aL*bH, aH*bH
    logic                     last;
    logic                     vld;
  } mac_pp_t;
endpackage

// File: rtl/mac_half_mult.sv
// Combinational HW x HW unsigned multiplier; one lane of the S2 partial-product array.
module mac_half_mult #(
  parameter int HW = 8
) (
  input  logic [HW-1:0]   a_i,
  input  logic [HW-1:0]   b_i,
  output logic [2*HW-1:0] p_o
);
  assign p_o = (2*HW)'(a_i) * (2*HW)'(b_i);
endmodule

// File: rtl/mac_pipe.sv
// Pipelined unsigned split-multiplier MAC with valid/ready streaming and packet accumulation.
// Optional clamp-on-overflow accumulation enabled by defining MAC_SATURATE_EN.
module mac_pipe
  import mac_pkg::*;
#(
  parameter int WIDTH     = MAC_WIDTH_DEF,
  parameter int ACC_WIDTH = MAC_ACC_WIDTH_DEF,
  parameter int CNT_WIDTH = MAC_CNT_WIDTH_DEF
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [WIDTH-1:0]     in_a,
  input  logic [WIDTH-1:0]     in_b,
  input  logic                 in_last,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [ACC_WIDTH-1:0] out_acc,
  output logic [CNT_WIDTH-1:0] out_count,
  output logic                 out_ovf
);
  localparam int H = WIDTH / 2;

  logic stall;
  logic in_fire;

  assign stall    = out_valid && !out_ready;
  assign in_ready = !stall;
  assign in_fire  = in_valid && in_ready;

  // S1: operand capture
  logic [WIDTH-1:0] a_q, b_q;
  logic             last1_q, v1_q;

  // S2: four half-width products
  logic [3:0][H-1:0]   ma, mb;
  logic [3:0][2*H-1:0] mp;
  mac_pp_t             s2_d, s2_q;

  for (genvar gi = 0; gi < 4; gi++) begin : g_pp
    assign ma[gi] = (gi % 2 == 1) ? a_q[WIDTH-1:H] : a_q[H-1:0];
    assign mb[gi] = (gi / 2 == 1) ? b_q[WIDTH-1:H] : b_q[H-1:0];
    mac_half_mult #(.HW(H)) u_mul (
      .a_i (ma[gi]),
      .b_i (mb[gi]),
      .p_o (mp[gi])
    );
  end

  always_comb begin
    s2_d      = '0;
    s2_d.last = last1_q;
    s2_d.vld  = v1_q;
    for (int i = 0; i < 4; i++) s2_d.pp[i] = MAC_PP_W'(mp[i]);
  end

  // S3: recombine products into the full-width beat sum
  logic [ACC_WIDTH-1:0] sum_d, sum_q;
  logic                 last3_q, v3_q;

  assign sum_d = ACC_WIDTH'(s2_q.pp[0])
               + ((ACC_WIDTH'(s2_q.pp[1]) + ACC_WIDTH'(s2_q.pp[2])) << H)
               + (ACC_WIDTH'(s2_q.pp[3]) << (2*H));

  always_ff @(posedge clk) begin
    if (rst) begin
      v1_q    <= 1'b0;
      a_q     <= '0;
      b_q     <= '0;
      last1_q <= 1'b0;
      s2_q    <= '0;
      v3_q    <= 1'b0;
      sum_q   <= '0;
      last3_q <= 1'b0;
    end else if (!stall) begin
      v1_q    <= in_fire;
      a_q     <= in_a;
      b_q     <= in_b;
      last1_q <= in_last;
      s2_q    <= s2_d;
      v3_q    <= s2_q.vld;
      sum_q   <= sum_d;
      last3_q <= s2_q.last;
    end
  end

  // Accumulate stage
  logic [ACC_WIDTH-1:0] acc_q, acc_d, acc_nx;
  logic [CNT_WIDTH-1:0] cnt_q, cnt_d, cnt_nx;
  logic                 ovf_q, ovf_d, ovf_nx;
  logic                 carry;
  logic                 out_vld_q, out_vld_d;
  logic [ACC_WIDTH-1:0] out_acc_q, out_acc_d;
  logic [CNT_WIDTH-1:0] out_cnt_q, out_cnt_d;
  logic                 out_ovf_q, out_ovf_d;

`ifdef MAC_SATURATE_EN
  logic [ACC_WIDTH:0] tot;
  assign tot    = {1'b0, acc_q} + {1'b0, sum_q};
  assign carry  = tot[ACC_WIDTH];
  // Once the packet has overflowed it stays pinned at all ones.
  assign acc_nx = ovf_nx ? '1 : tot[ACC_WIDTH-1:0];
`else
  assign carry  = 1'b0;
  assign acc_nx = acc_q + sum_q;
`endif

  assign ovf_nx = ovf_q | carry;
  assign cnt_nx = cnt_q + CNT_WIDTH'(1);

  always_comb begin
    acc_d     = acc_q;
    cnt_d     = cnt_q;
    ovf_d     = ovf_q;
    out_vld_d = out_vld_q;
    out_acc_d = out_acc_q;
    out_cnt_d = out_cnt_q;
    out_ovf_d = out_ovf_q;
    if (!stall) begin
      out_vld_d = 1'b0;
      if (v3_q) begin
        if (last3_q) begin
          out_vld_d = 1'b1;
          out_acc_d = acc_nx;
          out_cnt_d = cnt_nx;
          out_ovf_d = ovf_nx;
          acc_d     = '0;
          cnt_d     = '0;
          ovf_d     = 1'b0;
        end else begin
          acc_d = acc_nx;
          cnt_d = cnt_nx;
          ovf_d = ovf_nx;
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      acc_q     <= '0;
      cnt_q     <= '0;
      ovf_q     <= 1'b0;
      out_vld_q <= 1'b0;
      out_acc_q <= '0;
      out_cnt_q <= '0;
      out_ovf_q <= 1'b0;
    end else begin
      acc_q     <= acc_d;
      cnt_q     <= cnt_d;
      ovf_q     <= ovf_d;
      out_vld_q <= out_vld_d;
      out_acc_q <= out_acc_d;
      out_cnt_q <= out_cnt_d;
      out_ovf_q <= out_ovf_d;
    end
  end

  assign out_valid = out_vld_q;
  assign out_acc   = out_acc_q;
  assign out_count = out_cnt_q;
  assign out_ovf   = out_ovf_q;
endmodule

// File: tb/tb_mac_pipe.sv
// Directed bench for mac_pipe: a default 40-bit instance plus a 32-bit instance for overflow.
module tb_mac_pipe;
  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid;
  logic        in_ready, in_ready32;
  logic [15:0] in_a, in_b;
  logic        in_last;
  logic        out_valid, out_valid32;
  logic        out_ready;
  logic [39:0] out_acc;
  logic [31:0] out_acc32;
  logic [7:0]  out_count, out_count32;
  logic        out_ovf, out_ovf32;

  int n_assert = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  mac_pipe dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .in_a(in_a), .in_b(in_b), .in_last(in_last),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_acc(out_acc), .out_count(out_count), .out_ovf(out_ovf)
  );

  mac_pipe #(.ACC_WIDTH(32)) dut32 (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready32),
    .in_a(in_a), .in_b(in_b), .in_last(in_last),
    .out_valid(out_valid32), .out_ready(out_ready),
    .out_acc(out_acc32), .out_count(out_count32), .out_ovf(out_ovf32)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic send(input logic [15:0] a, input logic [15:0] b, input logic last);
    in_valid = 1'b1;
    in_a     = a;
    in_b     = b;
    in_last  = last;
    tick();
    in_valid = 1'b0;
    in_last  = 1'b0;
  endtask

  task automatic wait_result(input string tag);
    for (int i = 0; i < 20; i++) begin
      if (out_valid) break;
      tick();
    end
    chk(tag, {63'd0, out_valid}, 64'd1);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b1; in_valid = 1'b0; in_a = '0; in_b = '0; in_last = 1'b0; out_ready = 1'b1;
    tick(); tick();
    rst = 1'b0;
    chk("rst_out_valid", {63'd0, out_valid}, 64'd0);
    chk("rst_out_acc",   {24'd0, out_acc},   64'd0);
    chk("rst_out_count", {56'd0, out_count}, 64'd0);
    chk("rst_out_ovf",   {63'd0, out_ovf},   64'd0);
    chk("rst_in_ready",  {63'd0, in_ready},  64'd1);

    // Three-beat packet: 12 + 30 + 56, result three edges after the last beat
    send(16'd3, 16'd4, 1'b0);
    send(16'd5, 16'd6, 1'b0);
    send(16'd7, 16'd8, 1'b1);
    tick(); tick();
    chk("lat_not_yet", {63'd0, out_valid}, 64'd0);
    tick();
    chk("p3_valid", {63'd0, out_valid}, 64'd1);
    chk("p3_acc",   {24'd0, out_acc},   64'd98);
    chk("p3_count", {56'd0, out_count}, 64'd3);
    chk("p3_ovf",   {63'd0, out_ovf},   64'd0);
    tick();
    chk("p3_drop", {63'd0, out_valid}, 64'd0);

    // Cross-half carries
    send(16'hFFFF, 16'hFFFF, 1'b1);
    wait_result("max_valid");
    chk("max_acc",   {24'd0, out_acc},   64'hFFFE0001);
    chk("max_count", {56'd0, out_count}, 64'd1);
    tick();

    // Back-to-back packets
    send(16'd1, 16'd1, 1'b0);
    send(16'd2, 16'd2, 1'b1);
    send(16'd3, 16'd3, 1'b0);
    send(16'd4, 16'd4, 1'b1);
    wait_result("b2b1_valid");
    chk("b2b1_acc",   {24'd0, out_acc},   64'd5);
    chk("b2b1_count", {56'd0, out_count}, 64'd2);
    tick();
    chk("b2b_gap", {63'd0, out_valid}, 64'd0);
    tick();
    chk("b2b2_valid", {63'd0, out_valid}, 64'd1);
    chk("b2b2_acc",   {24'd0, out_acc},   64'd25);
    chk("b2b2_count", {56'd0, out_count}, 64'd2);
    tick();

    // Backpressure with beats in flight and a beat waiting at the input
    out_ready = 1'b0;
    send(16'd2, 16'd5, 1'b1);
    send(16'd3, 16'd3, 1'b0);
    send(16'd1, 16'd4, 1'b1);
    tick();
    in_valid = 1'b1; in_a = 16'd6; in_b = 16'd1; in_last = 1'b1;
    for (int i = 0; i < 4; i++) begin
      chk("bp_valid",    {63'd0, out_valid}, 64'd1);
      chk("bp_in_ready", {63'd0, in_ready},  64'd0);
      chk("bp_acc",      {24'd0, out_acc},   64'd10);
      chk("bp_count",    {56'd0, out_count}, 64'd1);
      tick();
    end
    out_ready = 1'b1;
    tick();
    in_valid = 1'b0; in_last = 1'b0;
    wait_result("bp2_valid");
    chk("bp2_acc",   {24'd0, out_acc},   64'd13);
    chk("bp2_count", {56'd0, out_count}, 64'd2);
    tick();
    wait_result("bp3_valid");
    chk("bp3_acc",   {24'd0, out_acc},   64'd6);
    chk("bp3_count", {56'd0, out_count}, 64'd1);
    tick();

    // Reset mid-packet discards partial state
    send(16'd9, 16'd9, 1'b0);
    send(16'd9, 16'd9, 1'b0);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    chk("mid_rst_valid", {63'd0, out_valid}, 64'd0);
    send(16'd2, 16'd3, 1'b1);
    wait_result("mid_valid");
    chk("mid_acc",   {24'd0, out_acc},   64'd6);
    chk("mid_count", {56'd0, out_count}, 64'd1);
    tick();
    for (int i = 0; i < 4; i++) begin
      chk("mid_no_extra", {63'd0, out_valid}, 64'd0);
      tick();
    end

    // 32-bit accumulator overflow
    send(16'hFFFF, 16'hFFFF, 1'b0);
    send(16'hFFFF, 16'hFFFF, 1'b0);
    send(16'hFFFF, 16'hFFFF, 1'b1);
    wait_result("ovf_valid");
    chk("ovf_valid32", {63'd0, out_valid32}, 64'd1);
    chk("ovf_count32", {56'd0, out_count32}, 64'd3);
    chk("ovf_acc40",   {24'd0, out_acc},     64'h2FFFA0003);
    chk("ovf_ovf40",   {63'd0, out_ovf},     64'd0);
`ifdef MAC_SATURATE_EN
    chk("ovf_acc32",   {32'd0, out_acc32},   64'hFFFFFFFF);
    chk("ovf_ovf32",   {63'd0, out_ovf32},   64'd1);
`else
    chk("ovf_acc32",   {32'd0, out_acc32},   64'hFFFA0003);
    chk("ovf_ovf32",   {63'd0, out_ovf32},   64'd0);
`endif
    tick();
    chk("ovf_drop", {63'd0, out_valid32}, 64'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end
endmodule
